// File: rtl/block_accumulator.sv
// Drains one block of 2**LOGDEPTH products from the multiplier's read stream.
// Reports the unsigned sum, the maximum and the beat count, held until the consumer acknowledges.
module block_accumulator #(
  parameter int LOGDEPTH  = 6,
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = WIDTH + LOGDEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN_start,
  output logic                 RDY_start,
  output logic                 EN_blockRead,
  input  logic                 VALID_memVal,
  input  logic [WIDTH-1:0]     memVal_data,
  output logic                 VALID_result,
  input  logic                 EN_resultAck,
  output logic [ACC_WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [LOGDEPTH:0]    beat_cnt,
  output logic                 ERR_stray
);

  localparam int DEPTH = 1 << LOGDEPTH;
  localparam logic [LOGDEPTH:0] LAST_BEAT = (LOGDEPTH + 1)'(DEPTH - 1);
  localparam logic [LOGDEPTH:0] CNT_ONE   = (LOGDEPTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   sum_q,   sum_d;
  logic [WIDTH-1:0]       max_q,   max_d;
  logic [LOGDEPTH:0]      cnt_q,   cnt_d;
  logic                   err_q,   err_d;

  function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (EN_start) begin
          state_d = REQ;
          sum_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (VALID_memVal) begin
          err_d = 1'b1;
        end
      end
      // REQ and ACCUM accept beats identically; REQ only differs in raising EN_blockRead.
      REQ, ACCUM: begin
        if (VALID_memVal) begin
          sum_d   = sum_q + ACC_WIDTH'(memVal_data);
          max_d   = umax(max_q, memVal_data);
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == LAST_BEAT) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (VALID_memVal) err_d = 1'b1;
        if (EN_resultAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign RDY_start    = (state_q == IDLE);
  assign EN_blockRead = (state_q == REQ);
  assign VALID_result = (state_q == DONE);
  assign sum_out      = sum_q;
  assign max_out      = max_q;
  assign beat_cnt     = cnt_q;
  assign ERR_stray    = err_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Randomized bench for block_accumulator: a queue-based transaction model is compared every cycle,
// with literal expectations pinning the directed scenarios.
module tb_block_accumulator;

  localparam int LOGDEPTH  = 6;
  localparam int WIDTH     = 32;
  localparam int ACC_WIDTH = WIDTH + LOGDEPTH;
  localparam int DEPTH     = 1 << LOGDEPTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 EN_start = 1'b0;
  logic                 RDY_start;
  logic                 EN_blockRead;
  logic                 VALID_memVal = 1'b0;
  logic [WIDTH-1:0]     memVal_data = '0;
  logic                 VALID_result;
  logic                 EN_resultAck = 1'b0;
  logic [ACC_WIDTH-1:0] sum_out;
  logic [WIDTH-1:0]     max_out;
  logic [LOGDEPTH:0]    beat_cnt;
  logic                 ERR_stray;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  block_accumulator #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .rst(rst), .EN_start(EN_start), .RDY_start(RDY_start),
    .EN_blockRead(EN_blockRead), .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .VALID_result(VALID_result), .EN_resultAck(EN_resultAck), .sum_out(sum_out),
    .max_out(max_out), .beat_cnt(beat_cnt), .ERR_stray(ERR_stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a block is "open" until DEPTH beats are collected,
  // then a result is "pending" until acknowledged. Outputs derive from the beat list.
  bit               m_open = 1'b0;
  bit               m_pending = 1'b0;
  bit               m_err = 1'b0;
  logic [WIDTH-1:0] m_beats[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_open = 1'b0; m_pending = 1'b0; m_err = 1'b0; m_beats.delete();
    end else if (m_open) begin
      if (VALID_memVal) begin
        m_beats.push_back(memVal_data);
        if (m_beats.size() == DEPTH) begin m_open = 1'b0; m_pending = 1'b1; end
      end
    end else if (m_pending) begin
      if (VALID_memVal) m_err = 1'b1;
      if (EN_resultAck) m_pending = 1'b0;
    end else begin
      if (EN_start) begin m_open = 1'b1; m_err = 1'b0; m_beats.delete(); end
      else if (VALID_memVal) m_err = 1'b1;
    end
  end

  function automatic logic [63:0] model_sum();
    logic [63:0] s = 0;
    foreach (m_beats[k]) s += 64'(m_beats[k]);
    return s;
  endfunction

  function automatic logic [63:0] model_max();
    logic [63:0] m = 0;
    foreach (m_beats[k]) if (64'(m_beats[k]) > m) m = 64'(m_beats[k]);
    return m;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdy_start",    64'(RDY_start),    64'(!m_open && !m_pending));
      check("en_blockread", 64'(EN_blockRead), 64'(m_open && m_beats.size() == 0));
      check("valid_result", 64'(VALID_result), 64'(m_pending));
      check("err_stray",    64'(ERR_stray),    64'(m_err));
      check("sum_out",      64'(sum_out),      model_sum());
      check("max_out",      64'(max_out),      model_max());
      check("beat_cnt",     64'(beat_cnt),     64'(m_beats.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] beat_val(input int mode, input int i);
    case (mode)
      0:       return WIDTH'(i);
      1:       return '1;
      2:       return WIDTH'(5);
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic run_block(input int mode, input int pre_delay, input int maxgap,
                           input int nbeats, input bit poke_start);
    EN_start = 1'b1;
    tick();
    EN_start = 1'b0;
    check("start_clears_err", 64'(ERR_stray), 64'd0);
    check("req_blockread", 64'(EN_blockRead), 64'd1);
    check("req_rdy_low", 64'(RDY_start), 64'd0);
    for (int d = 0; d < pre_delay; d++) begin
      tick();
      check("blockread_held", 64'(EN_blockRead), 64'd1);
    end
    for (int i = 0; i < nbeats; i++) begin
      VALID_memVal = 1'b1;
      memVal_data  = beat_val(mode, i);
      if (poke_start && i == 10) EN_start = 1'b1;
      tick();
      VALID_memVal = 1'b0;
      EN_start     = 1'b0;
      if (i == 0) check("blockread_drop", 64'(EN_blockRead), 64'd0);
      if (i < nbeats - 1 && maxgap > 0) begin
        int gap;
        gap = $urandom_range(0, maxgap);
        repeat (gap) tick();
      end
    end
  endtask

  task automatic wait_result();
    int budget;
    budget = 0;
    while (!VALID_result && budget < 200) begin
      tick();
      budget++;
    end
    check("result_timeout", 64'(VALID_result), 64'd1);
  endtask

  task automatic ack_result();
    EN_resultAck = 1'b1;
    tick();
    EN_resultAck = 1'b0;
    check("ack_rdy", 64'(RDY_start), 64'd1);
    check("ack_valid_low", 64'(VALID_result), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_rdy", 64'(RDY_start), 64'd1);
    check("rst_blockread", 64'(EN_blockRead), 64'd0);
    check("rst_valid", 64'(VALID_result), 64'd0);
    check("rst_sum", 64'(sum_out), 64'd0);
    check("rst_max", 64'(max_out), 64'd0);
    check("rst_cnt", 64'(beat_cnt), 64'd0);
    check("rst_err", 64'(ERR_stray), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Stray beat in IDLE
    VALID_memVal = 1'b1;
    memVal_data  = 32'd7;
    tick();
    VALID_memVal = 1'b0;
    check("stray_err", 64'(ERR_stray), 64'd1);
    check("stray_sum", 64'(sum_out), 64'd0);
    tick();

    // Ramp block, back-to-back, EN_start poked mid-ACCUM
    run_block(0, 0, 0, DEPTH, 1'b1);
    check("ramp_latency", 64'(VALID_result), 64'd1);
    check("ramp_sum", 64'(sum_out), 64'd2016);
    check("ramp_max", 64'(max_out), 64'd63);
    check("ramp_cnt", 64'(beat_cnt), 64'd64);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) EN_start = 1'b1;
      tick();
      EN_start = 1'b0;
      check("hold_valid", 64'(VALID_result), 64'd1);
      check("hold_sum", 64'(sum_out), 64'd2016);
      check("hold_max", 64'(max_out), 64'd63);
      check("hold_cnt", 64'(beat_cnt), 64'd64);
    end
    ack_result();
    check("post_ack_sum_kept", 64'(sum_out), 64'd2016);
    tick();

    // Saturation block
    run_block(1, 0, 0, DEPTH, 1'b0);
    check("sat_valid", 64'(VALID_result), 64'd1);
    check("sat_sum", 64'(sum_out), 64'h3F_FFFF_FFC0);
    check("sat_max", 64'(max_out), 64'hFFFF_FFFF);
    ack_result();

    // Gapped block with a long upstream delay
    run_block(2, 20, 3, DEPTH, 1'b0);
    wait_result();
    check("gap_sum", 64'(sum_out), 64'd320);
    check("gap_max", 64'(max_out), 64'd5);
    check("gap_cnt", 64'(beat_cnt), 64'd64);
    ack_result();

    // Random blocks, with stray beats while the result is pending
    for (int b = 0; b < 6; b++) begin
      run_block(3, $urandom_range(0, 5), 3, DEPTH, 1'b0);
      wait_result();
      repeat ($urandom_range(0, 4)) begin
        VALID_memVal = ($urandom_range(0, 3) == 0);
        memVal_data  = WIDTH'($urandom);
        tick();
        VALID_memVal = 1'b0;
      end
      ack_result();
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset in the middle of a block
    run_block(0, 0, 0, 31, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_blockread", 64'(EN_blockRead), 64'd0);
    check("midrst_cnt", 64'(beat_cnt), 64'd0);
    check("midrst_sum", 64'(sum_out), 64'd0);
    check("midrst_rdy", 64'(RDY_start), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    run_block(0, 2, 0, DEPTH, 1'b0);
    check("fresh_valid", 64'(VALID_result), 64'd1);
    check("fresh_sum", 64'(sum_out), 64'd2016);
    check("fresh_max", 64'(max_out), 64'd63);
    ack_result();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
